// File: rtl/fram_bank_arbiter_pkg.sv
// Shared definitions for the feature-SRAM bank arbiter: default geometry,
// write-buffer entry layout and the low-order bank interleave helper.
package fram_arb_pkg;

    localparam int unsigned ADDR_WIDTH_DFLT = 12;
    localparam int unsigned DATA_WIDTH_DFLT = 32;
    localparam int unsigned BANK_NUM_DFLT   = 4;
    localparam int unsigned BANK_W_DFLT     = $clog2(BANK_NUM_DFLT);
    localparam int unsigned ROW_W_DFLT      = ADDR_WIDTH_DFLT - BANK_W_DFLT;

    typedef struct packed {
        logic [ADDR_WIDTH_DFLT-1:0] addr;
        logic [DATA_WIDTH_DFLT-1:0] data;
    } wbuf_entry_t;

    // Bank index of a word address; bank_num must be a power of two.
    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int unsigned bank_num);
        return addr & (bank_num - 32'd1);
    endfunction

endpackage

// File: rtl/fram_bank_arbiter_if.sv
// Read-port and write-port handshake bundle between the compute/CU
// requesters (master) and the bank arbiter (slave).
interface fram_bank_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  rp_valid;
    logic                  rp_ready;
    logic [ADDR_WIDTH-1:0] rp_addr;
    logic                  rp_rvalid;
    logic [DATA_WIDTH-1:0] rp_rdata;
    logic                  wp_valid;
    logic                  wp_ready;
    logic [ADDR_WIDTH-1:0] wp_addr;
    logic [DATA_WIDTH-1:0] wp_wdata;

    modport master (
        output rp_valid, rp_addr, wp_valid, wp_addr, wp_wdata,
        input  rp_ready, rp_rvalid, rp_rdata, wp_ready
    );

    modport slave (
        input  rp_valid, rp_addr, wp_valid, wp_addr, wp_wdata,
        output rp_ready, rp_rvalid, rp_rdata, wp_ready
    );
endinterface

// File: rtl/fram_wbuf_fifo.sv
// Deferred-write FIFO with wrap-flag pointers and a parallel address
// compare over the occupied entries that returns the youngest match.
module fram_wbuf_fifo #(
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    input  logic [AW-1:0] cam_addr,
    output logic          cam_hit,
    output logic [DW-1:0] cam_data
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] idx;
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_addr = addr_mem[rd_ptr[PTR_W-1:0]];
    assign head_data = data_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr[PTR_W-1:0]] <= push_addr;
            data_mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    // Scan oldest to youngest so the last hit left standing is the youngest.
    always_comb begin
        cam_hit  = 1'b0;
        cam_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr[PTR_W-1:0] + PTR_W'(i);
            if ((i < 32'(count)) && (addr_mem[idx] == cam_addr)) begin
                cam_hit  = 1'b1;
                cam_data = data_mem[idx];
            end
        end
    end
endmodule

// File: rtl/fram_bank_arbiter.sv
// Routes one read port and one write port onto BANK_NUM interleaved BRAM banks,
// deferring conflicting writes. Optional statistics: define FRAM_ARB_STATS_EN.
module fram_bank_arbiter
    import fram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DFLT,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DFLT,
    parameter int unsigned BANK_NUM     = BANK_NUM_DFLT,
    parameter int unsigned WBUF_DEPTH   = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    fram_bank_arbiter_if.slave                                 bus,
    output logic [BANK_NUM*(ADDR_WIDTH-$clog2(BANK_NUM))-1:0]  bram_addr,
    output logic [BANK_NUM*DATA_WIDTH-1:0]                     bram_wdata,
    output logic [BANK_NUM-1:0]                                bram_we,
    output logic [BANK_NUM-1:0]                                bram_en,
    input  logic [BANK_NUM*DATA_WIDTH-1:0]                     bram_rdata,
    output logic                                               wb_pending,
    output logic                                               bank_conflict
`ifdef FRAM_ARB_STATS_EN
    ,
    input  logic                                               stat_clr,
    output logic [31:0]                                        stat_conflicts,
    output logic [31:0]                                        stat_stalls
`endif
);
    localparam int unsigned BANK_IDX_W = $clog2(BANK_NUM);
    localparam int unsigned ROW_W      = ADDR_WIDTH - BANK_IDX_W;
    localparam int unsigned CNT_W      = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic                  vld;
        logic [BANK_IDX_W-1:0] bank;
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
    } rd_pipe_t;

    logic                  alive;
    logic [CNT_W-1:0]      starve_cnt;
    logic                  stall_force;
    logic                  rd_acc, wr_acc;
    logic [BANK_IDX_W-1:0] rd_bank, wr_bank, head_bank, w_bank;
    logic [ROW_W-1:0]      w_row;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  head_blocked, head_issue, wr_conflict, bypass, push, w_en;
    logic                  full, empty, cam_hit;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data, cam_data, bram_sel;
    rd_pipe_t              pipe [READ_LATENCY];
    rd_pipe_t              ret;

    // Ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    assign stall_force  = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign bus.rp_ready = alive && !stall_force;
    assign bus.wp_ready = alive && !full;
    assign rd_acc       = bus.rp_valid && bus.rp_ready;
    assign wr_acc       = bus.wp_valid && bus.wp_ready;

    assign rd_bank   = BANK_IDX_W'(bank_of(32'(bus.rp_addr), BANK_NUM));
    assign wr_bank   = BANK_IDX_W'(bank_of(32'(bus.wp_addr), BANK_NUM));
    assign head_bank = BANK_IDX_W'(bank_of(32'(head_addr), BANK_NUM));

    assign head_blocked  = !empty && rd_acc && (rd_bank == head_bank);
    assign head_issue    = !empty && !head_blocked;
    assign wr_conflict   = wr_acc && rd_acc && (wr_bank == rd_bank);
    assign bypass        = wr_acc && empty && !wr_conflict;
    assign push          = wr_acc && !bypass;
    assign bank_conflict = wr_conflict;
    assign wb_pending    = !empty;

    assign w_en   = head_issue || bypass;
    assign w_bank = head_issue ? head_bank : wr_bank;
    assign w_row  = head_issue ? head_addr[ADDR_WIDTH-1:BANK_IDX_W] : bus.wp_addr[ADDR_WIDTH-1:BANK_IDX_W];
    assign w_data = head_issue ? head_data : bus.wp_wdata;

    fram_wbuf_fifo #(
        .AW    (ADDR_WIDTH),
        .DW    (DATA_WIDTH),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (bus.wp_addr),
        .push_data (bus.wp_wdata),
        .pop       (head_issue),
        .full      (full),
        .empty     (empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .cam_addr  (bus.rp_addr),
        .cam_hit   (cam_hit),
        .cam_data  (cam_data)
    );

    always_comb begin
        bram_en    = '0;
        bram_we    = '0;
        bram_addr  = '0;
        bram_wdata = '0;
        for (int unsigned b = 0; b < BANK_NUM; b++) begin
            if (rd_acc && (rd_bank == BANK_IDX_W'(b))) begin
                bram_en[b]                   = 1'b1;
                bram_addr[b*ROW_W +: ROW_W]  = bus.rp_addr[ADDR_WIDTH-1:BANK_IDX_W];
            end else if (w_en && (w_bank == BANK_IDX_W'(b))) begin
                bram_en[b]                              = 1'b1;
                bram_we[b]                              = 1'b1;
                bram_addr[b*ROW_W +: ROW_W]             = w_row;
                bram_wdata[b*DATA_WIDTH +: DATA_WIDTH]  = w_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            starve_cnt <= '0;
        else if (head_blocked) starve_cnt <= starve_cnt + 1'b1;
        else                   starve_cnt <= '0;
    end

    // Forwarded data is captured at acceptance and travels with the bank select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{vld: rd_acc, bank: rd_bank, hit: cam_hit, data: cam_data};
            for (int unsigned i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign ret = pipe[READ_LATENCY-1];

    always_comb begin
        bram_sel = '0;
        for (int unsigned b = 0; b < BANK_NUM; b++) begin
            if (ret.bank == BANK_IDX_W'(b)) bram_sel = bram_rdata[b*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.rp_rvalid = ret.vld;
    assign bus.rp_rdata  = !ret.vld ? '0 : (ret.hit ? ret.data : bram_sel);

`ifdef FRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_conflicts <= '0;
            stat_stalls    <= '0;
        end else if (stat_clr) begin
            stat_conflicts <= '0;
            stat_stalls    <= '0;
        end else begin
            if (bank_conflict && (stat_conflicts != '1)) stat_conflicts <= stat_conflicts + 1'b1;
            if (stall_force && (stat_stalls != '1))      stat_stalls    <= stat_stalls + 1'b1;
        end
    end
`endif
endmodule
